// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1/8N2 serializer with a registered TX line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic                          cfg_stop2_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [LW-1:0]    r_level;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_divCnt;
    logic [2:0]       r_bitCnt;
    logic             r_stop2;
    logic             r_tx;
    logic             r_busy;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_bitEnd;
    logic             w_lastStop;
    logic             w_txNext;
    logic [7:0]       w_head;

    assign ready_o    = (r_level != LW'(FIFO_DEPTH));
    assign level_o    = r_level;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;
    assign w_head     = r_mem[r_rdPtr];
    assign w_push     = valid_i && ready_o;
    assign w_bitEnd   = (r_divCnt == r_div);
    assign w_lastStop = !r_stop2 || r_bitCnt[0];
    // A pop happens either from IDLE or exactly at the end of the last stop bit,
    // which is what makes back-to-back frames gapless.
    assign w_pop      = cfg_en_i && (r_level != '0) &&
                        ((r_state == IDLE) ||
                         ((r_state == STOP) && w_bitEnd && w_lastStop));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // The line value is derived from the current state and registered, so tx_o
    // trails the state by one cycle and every bit still lasts div+1 cycles.
    always_comb begin
        w_txNext = 1'b1;
        case (r_state)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txNext = r_parity;
`endif
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_div    <= '0;
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_stop2  <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_tx   <= w_txNext;
            r_busy <= (r_state != IDLE);
            if (w_pop) begin
                r_shift  <= w_head;
                r_div    <= cfg_div_i;
                r_stop2  <= cfg_stop2_i;
                r_divCnt <= '0;
                r_bitCnt <= '0;
                r_state  <= START;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^w_head;
`endif
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    START: begin
                        if (w_bitEnd) begin
                            r_divCnt <= '0;
                            r_state  <= DATA;
                        end else begin
                            r_divCnt <= r_divCnt + DIV_W'(1);
                        end
                    end
                    DATA: begin
                        if (w_bitEnd) begin
                            r_divCnt <= '0;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            if (r_bitCnt == 3'd7) begin
                                r_bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
                                r_state  <= PARITY;
`else
                                r_state  <= STOP;
`endif
                            end else begin
                                r_bitCnt <= r_bitCnt + 3'd1;
                            end
                        end else begin
                            r_divCnt <= r_divCnt + DIV_W'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (w_bitEnd) begin
                            r_divCnt <= '0;
                            r_state  <= STOP;
                        end else begin
                            r_divCnt <= r_divCnt + DIV_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (w_bitEnd) begin
                            r_divCnt <= '0;
                            if (!w_lastStop) begin
                                r_bitCnt <= 3'd1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_divCnt <= r_divCnt + DIV_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer: frame shape, latency,
// back-to-back framing, FIFO full/wrap, config latching and async reset.
module tb_uart_tx_serializer;

   logic        clk;
   logic        rst;
   logic        cfgEn;
   logic [15:0] cfgDiv;
   logic        cfgStop2;
   logic [7:0]  dataIn;
   logic        validIn;
   logic        ready;
   logic        txLine;
   logic        busy;
   logic [2:0]  level;

   int errCount   = 0;
   int checkCount = 0;

   uart_tx_serializer #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cfg_en_i    (cfgEn),
      .cfg_div_i   (cfgDiv),
      .cfg_stop2_i (cfgStop2),
      .data_i      (dataIn),
      .valid_i     (validIn),
      .ready_o     (ready),
      .tx_o        (txLine),
      .busy_o      (busy),
      .level_o     (level)
   );

   // Free-running 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      int n;
      n = 0;
      validIn = 1'b1;
      dataIn  = value;
      while (!ready && n < 400) begin
         tick();
         n++;
      end
      if (!ready) checkOutput("push_timeout", 32'(ready), 32'd1);
      tick();
      validIn = 1'b0;
   endtask

   task automatic waitStart(input string tag, output int waited);
      waited = 0;
      while (txLine !== 1'b0 && waited < 400) begin
         tick();
         waited++;
      end
      if (txLine !== 1'b0) checkOutput({tag, "_start_timeout"}, 32'(txLine), 32'd0);
   endtask

   // Checks one frame cycle by cycle; optionally changes config/enable at the start of data bit 2
   task automatic expectFrame(input string tag, input logic [7:0] value, input int div,
                              input bit stop2, input bit midChange, output int waited);
      logic expBits [0:11];
      int   nb;
      int   good;
      waitStart(tag, waited);
      if (txLine !== 1'b0) return;
      nb = 0;
      expBits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
         expBits[nb] = value[i];
         nb++;
      end
`ifdef UART_TX_PARITY_EN
      expBits[nb] = ^value; nb++;
`endif
      expBits[nb] = 1'b1; nb++;
      if (stop2) begin
         expBits[nb] = 1'b1;
         nb++;
      end
      for (int bi = 0; bi < nb; bi++) begin
         good = 0;
         for (int c = 0; c <= div; c++) begin
            if (!(bi == 0 && c == 0)) tick();
            if (midChange && bi == 3 && c == 0) begin
               cfgDiv   = 16'd9;
               cfgStop2 = 1'b0;
               cfgEn    = 1'b0;
            end
            if (txLine === expBits[bi]) good++;
         end
         checkOutput($sformatf("%s_bit%0d", tag, bi), good, div + 1);
      end
      checkOutput({tag, "_busy_last"}, 32'(busy), 32'd1);
   endtask

   initial begin
      int w;
      int highCnt;
      logic [7:0] vals [0:4];

      rst      = 1'b1;
      cfgEn    = 1'b0;
      cfgDiv   = 16'd3;
      cfgStop2 = 1'b0;
      dataIn   = 8'h00;
      validIn  = 1'b0;
      tick();
      tick();
      checkOutput("rst_tx", 32'(txLine), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_level", 32'(level), 32'd0);
      rst = 1'b0;
      tick();

      // Single byte, latency 2 from push to start edge
      cfgEn = 1'b1;
      applyStimulus(8'h55);
      expectFrame("t1", 8'h55, 3, 1'b0, 1'b0, w);
      checkOutput("t1_latency", w, 32'd2);
      tick();
      checkOutput("t1_busy_end", 32'(busy), 32'd0);
      checkOutput("t1_tx_idle", 32'(txLine), 32'd1);

      // Back-to-back "Hi\n"
      cfgDiv = 16'd7;
      applyStimulus(8'h48);
      applyStimulus(8'h69);
      applyStimulus(8'h0A);
      expectFrame("t2a", 8'h48, 7, 1'b0, 1'b0, w);
      expectFrame("t2b", 8'h69, 7, 1'b0, 1'b0, w);
      checkOutput("t2b_gap", w, 32'd1);
      expectFrame("t2c", 8'h0A, 7, 1'b0, 1'b0, w);
      checkOutput("t2c_gap", w, 32'd1);
      tick();
      checkOutput("t2_busy_end", 32'(busy), 32'd0);

      // Full FIFO and pointer wrap, three rounds
      cfgDiv = 16'd1;
      for (int rep = 0; rep < 3; rep++) begin
         cfgEn = 1'b0;
         for (int i = 0; i < 5; i++) vals[i] = 8'(8'h5A ^ (rep * 16 + i * 3 + 1));
         for (int i = 0; i < 4; i++) applyStimulus(vals[i]);
         checkOutput($sformatf("t3_r%0d_ready_full", rep), 32'(ready), 32'd0);
         checkOutput($sformatf("t3_r%0d_level_full", rep), 32'(level), 32'd4);
         validIn = 1'b1;
         dataIn  = vals[4];
         tick();
         checkOutput($sformatf("t3_r%0d_level_held", rep), 32'(level), 32'd4);
         cfgEn = 1'b1;
         applyStimulus(vals[4]);
         for (int i = 0; i < 5; i++) begin
            expectFrame($sformatf("t3_r%0d_f%0d", rep, i), vals[i], 1, 1'b0, 1'b0, w);
            if (i > 0) checkOutput($sformatf("t3_r%0d_f%0d_gap", rep, i), w, 32'd1);
         end
         tick();
         checkOutput($sformatf("t3_r%0d_level_end", rep), 32'(level), 32'd0);
      end

      // Simultaneous push and pop at level 1
      cfgEn  = 1'b0;
      cfgDiv = 16'd2;
      applyStimulus(8'h3C);
      cfgEn   = 1'b1;
      validIn = 1'b1;
      dataIn  = 8'hC3;
      tick();
      validIn = 1'b0;
      checkOutput("t4_level_pushpop", 32'(level), 32'd1);
      expectFrame("t4a", 8'h3C, 2, 1'b0, 1'b0, w);
      expectFrame("t4b", 8'hC3, 2, 1'b0, 1'b0, w);
      checkOutput("t4b_gap", w, 32'd1);

      // Mid-frame config/enable changes are ignored until the next frame
      tick();
      cfgDiv   = 16'd3;
      cfgStop2 = 1'b1;
      applyStimulus(8'h96);
      applyStimulus(8'h2D);
      expectFrame("t5a", 8'h96, 3, 1'b1, 1'b1, w);
      highCnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (txLine === 1'b1 && busy === 1'b0) highCnt++;
      end
      checkOutput("t5_idle_while_disabled", highCnt, 32'd20);
      checkOutput("t5_level_pending", 32'(level), 32'd1);
      cfgEn = 1'b1;
      expectFrame("t5b", 8'h2D, 9, 1'b0, 1'b0, w);
      checkOutput("t5b_latency", w, 32'd2);
      tick();

      // Asynchronous reset during data bit 3 of 0xA5
      cfgDiv   = 16'd3;
      cfgStop2 = 1'b0;
      applyStimulus(8'hA5);
      applyStimulus(8'h11);
      waitStart("t6", w);
      for (int i = 0; i < 17; i++) tick();
      checkOutput("t6_bit3_pre", 32'(txLine), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_tx", 32'(txLine), 32'd1);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_level", 32'(level), 32'd0);
      checkOutput("t6_rst_ready", 32'(ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(8'h31);
      expectFrame("t6b", 8'h31, 3, 1'b0, 1'b0, w);
      checkOutput("t6b_latency", w, 32'd2);
      tick();
      applyStimulus(8'h07);
      expectFrame("t6c", 8'h07, 3, 1'b0, 1'b0, w);
      checkOutput("t6c_latency", w, 32'd2);
      tick();
      checkOutput("t6_busy_end", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
